// File: rtl/wb_dest_pipe_pkg.sv
// Shared constants for the write-back destination pipeline: forwarding select
// encodings, special register numbers and default widths.
package wb_dest_pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_M    = 2'b01;
  localparam logic [1:0] FWD_W    = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: async active-high clear, hold has priority
// over bubble, bubble loads all-zero, otherwise the stage captures i_d.
module pipe_stage_reg #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_hold,
  input  logic         i_bubble,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Stage state: clear on reset, freeze on hold, zero on bubble, else advance.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (!i_hold) begin
      r_q <= i_bubble ? '0 : i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/wb_dest_pipe.sv
// Carries the execute-stage destination, control and result through the M and
// W stages to the register-file write port, and derives operand forwarding
// selects and the load-use stall from the in-flight destinations.
// Optional macro WB_FWD_CNT_EN adds a saturating count of forwarding cycles.
module wb_dest_pipe
  import wb_dest_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic [ADDR_W-1:0] waE,
  input  logic              regWriteE,
  input  logic              memToRegE,
  input  logic [DATA_W-1:0] resE,
  input  logic [ADDR_W-1:0] rsE,
  input  logic [ADDR_W-1:0] rtE,
  input  logic [ADDR_W-1:0] rsD,
  input  logic [ADDR_W-1:0] rtD,
  output logic [ADDR_W-1:0] waM,
  output logic              regWriteM,
  output logic              memToRegM,
  output logic [DATA_W-1:0] resM,
  output logic [ADDR_W-1:0] waW,
  output logic              regWriteW,
  output logic [DATA_W-1:0] resW,
  output logic [1:0]        fwdA,
  output logic [1:0]        fwdB,
  output logic              luStall
`ifdef WB_FWD_CNT_EN
  ,
  output logic [15:0]       fwdCnt
`endif
);

  localparam int unsigned MW = ADDR_W + 2 + DATA_W;
  localparam int unsigned WW = ADDR_W + 1 + DATA_W;
  localparam logic [ADDR_W-1:0] Zero = ADDR_W'(REG_ZERO);

  logic          w_wa_e_nz;
  logic [MW-1:0] w_m_d;
  logic [MW-1:0] w_m_q;
  logic [WW-1:0] w_w_d;
  logic [WW-1:0] w_w_q;

  // Writes to register 0 are squashed on entry so they never reach W or forward.
  assign w_wa_e_nz = (waE != Zero);
  assign w_m_d     = {waE, regWriteE & w_wa_e_nz, memToRegE, resE};

  pipe_stage_reg #(
    .W(MW)
  ) u_stage_m (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_hold   (hold),
    .i_bubble (flush),
    .i_d      (w_m_d),
    .o_q      (w_m_q)
  );

  assign {waM, regWriteM, memToRegM, resM} = w_m_q;
  assign w_w_d = {waM, regWriteM, resM};

  pipe_stage_reg #(
    .W(WW)
  ) u_stage_w (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_hold   (hold),
    .i_bubble (1'b0),
    .i_d      (w_w_d),
    .o_q      (w_w_q)
  );

  assign {waW, regWriteW, resW} = w_w_q;

  logic w_m_live;
  logic w_w_live;

  assign w_m_live = regWriteM && (waM != Zero);
  assign w_w_live = regWriteW && (waW != Zero);

  // Forward selects: the newer M result beats W when both match.
  always_comb begin
    fwdA = FWD_NONE;
    fwdB = FWD_NONE;
    if (w_m_live && (waM == rsE)) begin
      fwdA = FWD_M;
    end else if (w_w_live && (waW == rsE)) begin
      fwdA = FWD_W;
    end
    if (w_m_live && (waM == rtE)) begin
      fwdB = FWD_M;
    end else if (w_w_live && (waW == rtE)) begin
      fwdB = FWD_W;
    end
  end

  // Load in E whose destination is read by the instruction in D.
  always_comb begin
    luStall = memToRegE && regWriteE && w_wa_e_nz && ((waE == rsD) || (waE == rtD));
  end

`ifdef WB_FWD_CNT_EN
  logic [15:0] r_fwd_cnt;

  // Saturating count of non-held cycles in which either operand is forwarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_cnt <= '0;
    end else if (!hold && ((fwdA != FWD_NONE) || (fwdB != FWD_NONE))
                 && (r_fwd_cnt != 16'hFFFF)) begin
      r_fwd_cnt <= r_fwd_cnt + 16'd1;
    end
  end

  assign fwdCnt = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_wb_dest_pipe.sv
// Bench for wb_dest_pipe: a directed vector table walking the main scenarios,
// an asynchronous reset check, then randomized traffic against a stage model.
module tb_wb_dest_pipe;
  import wb_dest_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst, hold, flush;
  logic [4:0]  waE, rsE, rtE, rsD, rtD;
  logic        regWriteE, memToRegE;
  logic [31:0] resE;
  logic [4:0]  waM, waW;
  logic        regWriteM, memToRegM, regWriteW;
  logic [31:0] resM, resW;
  logic [1:0]  fwdA, fwdB;
  logic        luStall;
`ifdef WB_FWD_CNT_EN
  logic [15:0] fwdCnt;
`endif

  wb_dest_pipe #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .flush     (flush),
    .waE       (waE),
    .regWriteE (regWriteE),
    .memToRegE (memToRegE),
    .resE      (resE),
    .rsE       (rsE),
    .rtE       (rtE),
    .rsD       (rsD),
    .rtD       (rtD),
    .waM       (waM),
    .regWriteM (regWriteM),
    .memToRegM (memToRegM),
    .resM      (resM),
    .waW       (waW),
    .regWriteW (regWriteW),
    .resW      (resW),
    .fwdA      (fwdA),
    .fwdB      (fwdB),
    .luStall   (luStall)
`ifdef WB_FWD_CNT_EN
    ,
    .fwdCnt    (fwdCnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: contents of each stage as an instruction record.
  typedef struct {
    logic [4:0]  wa;
    logic        rw;
    logic        mr;
    logic [31:0] res;
  } instr_t;

  instr_t      mdl_m, mdl_w;
  logic [15:0] mdl_cnt;

  typedef struct {
    logic        h, f;
    logic [4:0]  wa;
    logic        rw, mr;
    logic [31:0] res;
    logic [4:0]  rs, rt, rsd, rtd;
    logic [4:0]  e_wam;
    logic        e_rwm, e_mrm;
    logic [31:0] e_resm;
    logic [4:0]  e_waw;
    logic        e_rww;
    logic [31:0] e_resw;
    logic [1:0]  e_fa, e_fb;
    logic        e_lu;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // An instruction is a forwarding source if it writes a nonzero register equal to src.
  function automatic logic [1:0] mdl_fwd(input logic [4:0] src);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (mdl_w.rw && mdl_w.wa != 5'd0 && mdl_w.wa == src) sel = FWD_W;
    if (mdl_m.rw && mdl_m.wa != 5'd0 && mdl_m.wa == src) sel = FWD_M;
    return sel;
  endfunction

  function automatic logic mdl_lu();
    return memToRegE && regWriteE && waE != 5'd0 && (waE == rsD || waE == rtD);
  endfunction

  task automatic mdl_reset();
    mdl_m   = '{wa: 5'd0, rw: 1'b0, mr: 1'b0, res: 32'd0};
    mdl_w   = mdl_m;
    mdl_cnt = 16'd0;
  endtask

  task automatic mdl_edge();
    instr_t bubble;
    bubble = '{wa: 5'd0, rw: 1'b0, mr: 1'b0, res: 32'd0};
    if (!hold) begin
      if ((mdl_fwd(rsE) != FWD_NONE || mdl_fwd(rtE) != FWD_NONE) && mdl_cnt != 16'hFFFF)
        mdl_cnt = mdl_cnt + 16'd1;
      mdl_w = mdl_m;
      mdl_w.mr = 1'b0;
      if (flush) mdl_m = bubble;
      else mdl_m = '{wa: waE, rw: regWriteE && waE != 5'd0, mr: memToRegE, res: resE};
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    mdl_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".waM"}, 64'(waM), 64'(mdl_m.wa));
    check({tag, ".regWriteM"}, 64'(regWriteM), 64'(mdl_m.rw));
    check({tag, ".memToRegM"}, 64'(memToRegM), 64'(mdl_m.mr));
    check({tag, ".resM"}, 64'(resM), 64'(mdl_m.res));
    check({tag, ".waW"}, 64'(waW), 64'(mdl_w.wa));
    check({tag, ".regWriteW"}, 64'(regWriteW), 64'(mdl_w.rw));
    check({tag, ".resW"}, 64'(resW), 64'(mdl_w.res));
    check({tag, ".fwdA"}, 64'(fwdA), 64'(mdl_fwd(rsE)));
    check({tag, ".fwdB"}, 64'(fwdB), 64'(mdl_fwd(rtE)));
    check({tag, ".luStall"}, 64'(luStall), 64'(mdl_lu()));
`ifdef WB_FWD_CNT_EN
    check({tag, ".fwdCnt"}, 64'(fwdCnt), 64'(mdl_cnt));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".outs"}, 64'({waM, regWriteM, memToRegM, waW, regWriteW}), 64'd0);
    check({tag, ".resM"}, 64'(resM), 64'd0);
    check({tag, ".resW"}, 64'(resW), 64'd0);
    check({tag, ".fwd"}, 64'({fwdA, fwdB}), 64'd0);
`ifdef WB_FWD_CNT_EN
    check({tag, ".fwdCnt"}, 64'(fwdCnt), 64'd0);
`endif
  endtask

  initial begin
    //            h  f  wa      rw mr res            rs      rt    rsd   rtd
    //            waM     rwM mrM resM           waW   rwW resW           fa    fb    lu
    vecs[0]  = '{1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 32'hDEAD_BEEF, 5'd0, 5'd3, 5'd0, 5'd0,
                 5'd8, 1'b1, 1'b0, 32'hDEAD_BEEF, 5'd0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 32'h1111, 5'd8, 5'd3, 5'd0, 5'd0,
                 5'd9, 1'b1, 1'b0, 32'h1111, 5'd8, 1'b1, 32'hDEAD_BEEF, 2'b10, 2'b00, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 32'h2222, 5'd9, 5'd3, 5'd0, 5'd0,
                 5'd9, 1'b1, 1'b0, 32'h2222, 5'd9, 1'b1, 32'h1111, 2'b01, 2'b00, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 32'h3333, 5'd9, 5'd3, 5'd0, 5'd0,
                 5'd0, 1'b0, 1'b0, 32'h0, 5'd9, 1'b1, 32'h2222, 2'b10, 2'b00, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h4444, 5'd0, 5'd3, 5'd0, 5'd0,
                 5'd0, 1'b0, 1'b0, 32'h4444, 5'd0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 32'h5555, 5'd0, 5'd3, 5'd0, 5'd4,
                 5'd4, 1'b1, 1'b1, 32'h5555, 5'd0, 1'b0, 32'h4444, 2'b00, 2'b00, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 32'h6666, 5'd4, 5'd3, 5'd0, 5'd5,
                 5'd4, 1'b1, 1'b1, 32'h6666, 5'd4, 1'b1, 32'h5555, 2'b01, 2'b00, 1'b0};
    for (int i = 7; i < 10; i++) begin
      vecs[i] = '{1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 32'h7777, 5'd4, 5'd3, 5'd0, 5'd0,
                  5'd4, 1'b1, 1'b1, 32'h6666, 5'd4, 1'b1, 32'h5555, 2'b01, 2'b00, 1'b0};
    end
    vecs[10] = '{1'b0, 1'b1, 5'd10, 1'b1, 1'b0, 32'h7777, 5'd4, 5'd3, 5'd0, 5'd0,
                 5'd0, 1'b0, 1'b0, 32'h0, 5'd4, 1'b1, 32'h6666, 2'b10, 2'b00, 1'b0};
    vecs[11] = '{1'b0, 1'b0, REG_RA, 1'b1, 1'b0, 32'hABCD, REG_RA, 5'd4, 5'd0, 5'd0,
                 REG_RA, 1'b1, 1'b0, 32'hABCD, 5'd0, 1'b0, 32'h0, 2'b01, 2'b00, 1'b0};

    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    waE = '0; rsE = '0; rtE = '0; rsD = '0; rtD = '0;
    regWriteE = 1'b0; memToRegE = 1'b0; resE = '0;
    mdl_reset();
    #12;
    check_all_zero("reset");
    check("reset.luStall", 64'(luStall), 64'd0);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      hold = vecs[i].h; flush = vecs[i].f;
      waE = vecs[i].wa; regWriteE = vecs[i].rw; memToRegE = vecs[i].mr; resE = vecs[i].res;
      rsE = vecs[i].rs; rtE = vecs[i].rt; rsD = vecs[i].rsd; rtD = vecs[i].rtd;
      cycle();
      check($sformatf("v%0d.waM", i), 64'(waM), 64'(vecs[i].e_wam));
      check($sformatf("v%0d.regWriteM", i), 64'(regWriteM), 64'(vecs[i].e_rwm));
      check($sformatf("v%0d.memToRegM", i), 64'(memToRegM), 64'(vecs[i].e_mrm));
      check($sformatf("v%0d.resM", i), 64'(resM), 64'(vecs[i].e_resm));
      check($sformatf("v%0d.waW", i), 64'(waW), 64'(vecs[i].e_waw));
      check($sformatf("v%0d.regWriteW", i), 64'(regWriteW), 64'(vecs[i].e_rww));
      check($sformatf("v%0d.resW", i), 64'(resW), 64'(vecs[i].e_resw));
      check($sformatf("v%0d.fwdA", i), 64'(fwdA), 64'(vecs[i].e_fa));
      check($sformatf("v%0d.fwdB", i), 64'(fwdB), 64'(vecs[i].e_fb));
      check($sformatf("v%0d.luStall", i), 64'(luStall), 64'(vecs[i].e_lu));
    end
`ifdef WB_FWD_CNT_EN
    check("table.fwdCnt", 64'(fwdCnt), 64'(mdl_cnt));
`endif

    // Asynchronous reset between edges while M holds a live write.
    hold = 1'b0; flush = 1'b0;
    #2;
    check("pre_async.regWriteM", 64'(regWriteM), 64'd1);
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    mdl_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model, with one more mid-run reset.
    for (int i = 0; i < 400; i++) begin
      hold      = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 4) == 0);
      waE       = 5'($urandom_range(0, 7));
      regWriteE = ($urandom_range(0, 3) != 0);
      memToRegE = ($urandom_range(0, 2) == 0);
      resE      = $urandom;
      rsE       = 5'($urandom_range(0, 7));
      rtE       = 5'($urandom_range(0, 7));
      rsD       = 5'($urandom_range(0, 7));
      rtD       = 5'($urandom_range(0, 7));
      cycle();
      check_model($sformatf("r%0d", i));
      if (i == 200) begin
        #2;
        rst = 1'b1;
        #1;
        mdl_reset();
        check_model("r_async");
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_dest_pipe.md
Name: wb_dest_pipe

Overview:
- Downstream of the execute-stage destination-register mux.
- Takes the selected write address `waE` (rd, rt or 31) with its control and result, and carries them through two registered stages, M and W, to the register-file write port.
- From the in-flight M/W destinations it also drives operand forwarding selects for the execute stage and a load-use stall for decode.

Parameters:
- DATA_W, 32, width of the carried result.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- hold  in  1  global freeze (memory wait); M and W keep their contents.
- flush  in  1  insert a bubble into M.
- waE  in  ADDR_W  destination address from the execute-stage destination mux.
- regWriteE  in  1  execute-stage instruction writes a register.
- memToRegE  in  1  execute-stage instruction is a load.
- resE  in  DATA_W  execute result (ALU output or link address).
- rsE, rtE  in  ADDR_W  execute-stage source operands.
- rsD, rtD  in  ADDR_W  decode-stage source operands.
- waM  out  ADDR_W  M-stage destination.
- regWriteM  out  1  M-stage write enable.
- memToRegM  out  1  M-stage load flag.
- resM  out  DATA_W  M-stage result.
- waW  out  ADDR_W  W-stage destination.
- regWriteW  out  1  register-file write enable.
- resW  out  DATA_W  W-stage result (W captures resM; load-data muxing is external).
- fwdA, fwdB  out  2  operand-forward select for rsE/rtE: 00 none, 01 from M, 10 from W.
- luStall  out  1  load-use stall request to decode.

Behaviour:
- Reset: rst high forces all M and W registers to 0 immediately, regardless of clk.
  - waM, waW, resM, resW, regWriteM, regWriteW and memToRegM are all 0.
  - fwdA, fwdB and luStall are therefore 00/00/0.
- Destination zero: if regWriteE=1 and waE=0, regWriteM is captured as 0. Register 0 is never written and never forwarded.
- Priority at each clk edge: hold, then flush, then normal advance.
- Normal advance (hold=0, flush=0):
  - M captures the E inputs.
  - W captures waM, regWriteM and resM.
  - Latency from E to W is exactly 2 cycles.
- Flush (hold=0, flush=1):
  - M becomes a bubble: regWriteM=0, memToRegM=0; waM and resM capture 0.
  - W still advances from the old M contents, so an instruction already in M is not lost.
- Hold=1: every register holds, including when flush=1 in the same cycle. The flush is dropped, not deferred; the controller reasserts it.
- Forwarding (combinational, no extra latency):
  - fwdA=01 when regWriteM=1, waM≠0 and waM==rsE.
  - Otherwise fwdA=10 when regWriteW=1, waW≠0 and waW==rsE.
  - Otherwise fwdA=00.
  - When M and W both match, M wins (newest value).
  - fwdB is identical using rtE.
  - A forward from M while memToRegM=1 is still reported as 01; the consumer is stalled by luStall first.
- Load-use stall (combinational):
  - luStall=1 when memToRegE=1, regWriteE=1, waE≠0 and (waE==rsD or waE==rtD).
  - The controller responds by stalling decode and asserting flush for one cycle.
- Reset mid-operation: in-flight M/W contents are discarded, no register-file write occurs after reset asserts, and normal operation resumes on the first edge after rst falls.

Optional Feature:
- Macro WB_FWD_CNT_EN.
- When defined:
  - Adds output fwdCnt [15:0], counting cycles with (fwdA≠00 or fwdB≠00) and hold=0.
  - The count saturates at 16'hFFFF and clears on rst.
- When undefined: port and logic are absent and the rest of the behaviour is identical.

Decomposition:
- Shared header/package holds:
  - localparams FWD_NONE=2'b00, FWD_M=2'b01, FWD_W=2'b10;
  - REG_ZERO=5'd0 and REG_RA=5'd31;
  - DATA_W and ADDR_W defaults.
- One sub-module, pipe_stage_reg, is natural:
  - a parameterised-width register with async rst, hold and bubble inputs;
  - instantiated once for M (bubble=flush) and once for W (bubble tied 0).
- Forwarding and stall compares stay in the top level.

Test Plan:
- Advance: waE=5'd8, regWriteE=1, resE=32'hDEAD_BEEF, 3 edges -> waM=8 after edge 1; waW=8, regWriteW=1, resW=DEAD_BEEF after edge 2.
- Forward priority: M holds wa=9 and W holds wa=9, rsE=9 -> fwdA=01. Next edge with a bubble entering M -> fwdA=10. rtE=3 -> fwdB=00 throughout.
- Register zero: waE=0, regWriteE=1 -> regWriteM=0; rsE=0 -> fwdA=00.
- Load-use: memToRegE=1, regWriteE=1, waE=4, rtD=4 -> luStall=1. rtD=5 -> luStall=0.
- Hold/flush: hold=1 and flush=1 for 3 cycles -> M/W unchanged. Then hold=0, flush=1 -> regWriteM=0, W receives the prior M.
- Async reset: assert rst between edges while regWriteM=1 -> all outputs 0 before the next clk edge; with WB_FWD_CNT_EN defined, fwdCnt=0.
